// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each producer uses a valid/ready handshake. A grant lasts up to MAX_BURST
// words, or until the granted producer drops valid. The grant then moves on
// in round-robin order, with one idle arbitration cycle between grants.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      asynchronous active-high reset
//   req_valid  per-requester word valid
//   req_data   per-requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  per-requester word accepted this cycle
//   full       FIFO full flag
//   wenb       FIFO write enable
//   din        FIFO write data
//   grant_vld  a grant is currently held
//   grant_id   index of the granted requester (meaningful when grant_vld)
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wenb,
  output logic [DATA_W-1:0]             din,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] grant_id_nxt;
  logic           grant_vld_nxt;
  logic [7:0]     burst_cnt, burst_cnt_nxt;

  logic [IDW-1:0] sel_idx;
  logic           sel_found;
  logic [IDW-1:0] next_ptr;
  logic           g_valid;
  logic [DATA_W-1:0] g_data;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Requester after the current grant, used as the next scan start point.
  always_comb begin
    if (grant_id == IDW'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id + IDW'(1);
    end
  end

  // Write path is purely combinational so full gates wenb in the same cycle
  // and the FIFO can never be overrun.
  always_comb begin
    g_valid   = req_valid[grant_id];
    g_data    = req_data[grant_id*DATA_W +: DATA_W];
    wenb      = (state == GRANT) && g_valid && !full;
    req_ready = '0;
    if (wenb) begin
      req_ready[grant_id] = 1'b1;
    end
    din = grant_vld ? g_data : '0;
  end

  // Next-state logic: arbitrate in IDLE, count words and release in GRANT.
  // A full stall leaves everything unchanged because wenb is low and the
  // granted requester is still valid.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_id_nxt  = grant_id;
    grant_vld_nxt = grant_vld;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_id_nxt  = sel_idx;
          grant_vld_nxt = 1'b1;
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (wenb) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
          if (burst_cnt == BURST_LAST) begin
            state_nxt     = IDLE;
            rr_ptr_nxt    = next_ptr;
            grant_vld_nxt = 1'b0;
          end
        end else if (!g_valid) begin
          state_nxt     = IDLE;
          rr_ptr_nxt    = next_ptr;
          grant_vld_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset takes effect immediately, dropping any word that
  // was being presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      grant_vld <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_id_nxt;
      grant_vld <= grant_vld_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4).
// Each producer is modelled by a list of words; the expected FIFO write
// order is pushed to a scoreboard and compared against the recorded writes.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int MAXC      = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        full = 1'b0;
  logic        wenb;
  logic [7:0]  din;
  logic        grant_vld;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .full     (full),
    .wenb     (wenb),
    .din      (din),
    .grant_vld(grant_vld),
    .grant_id (grant_id)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] wdata[4][16];
  int wcount[4];
  int widx[4];
  int start_at[4];
  logic full_at[MAXC];

  logic       tr_wenb[MAXC];
  logic [7:0] tr_din[MAXC];
  logic [1:0] tr_gid[MAXC];
  logic       tr_gvld[MAXC];
  logic [3:0] tr_ready[MAXC];
  logic       tr_full[MAXC];
  int ncyc;

  // Present each producer's current word; valid stays up until accepted.
  task automatic drive_inputs();
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      if (ncyc >= start_at[i] && widx[i] < wcount[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = wdata[i][widx[i]];
      end
    end
    full = (ncyc < MAXC) ? full_at[ncyc] : 1'b0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 4; i++) begin
      wcount[i] = 0;
      widx[i] = 0;
      start_at[i] = 0;
    end
    for (int c = 0; c < MAXC; c++) full_at[c] = 1'b0;
    sb.delete();
  endtask

  task automatic load_word(input int i, input logic [7:0] d);
    wdata[i][wcount[i]] = d;
    wcount[i]++;
  endtask

  task automatic expect_word(input int i, input logic [7:0] d);
    exp_t e;
    e.id = 2'(i);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ncyc = 0;
    drive_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_inputs();
  endtask

  // One clock cycle: sample outputs at negedge, advance producers after posedge.
  task automatic run_cycle();
    logic [3:0] acc;
    @(negedge clk);
    tr_wenb[ncyc]  = wenb;
    tr_din[ncyc]   = din;
    tr_gid[ncyc]   = grant_id;
    tr_gvld[ncyc]  = grant_vld;
    tr_ready[ncyc] = req_ready;
    tr_full[ncyc]  = full;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) widx[i]++;
    ncyc++;
    drive_inputs();
  endtask

  task automatic test_reset();
    clear_stim();
    load_word(0, 8'h55);
    reset = 1'b1;
    ncyc = 0;
    drive_inputs();
    #1;
    n_cmp++;
    if ({wenb, req_ready, grant_vld, din, grant_id} !== 16'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_outputs: got wenb=%b ready=%b gvld=%b din=%h gid=%0d, expected all zero",
               wenb, req_ready, grant_vld, din, grant_id);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({wenb, req_ready, grant_vld, din} !== 14'h0) begin
      n_mis++;
      $display("[TB] FAIL reset_hold: got wenb=%b ready=%b gvld=%b din=%h, expected all zero",
               wenb, req_ready, grant_vld, din);
    end
    reset = 1'b0;
    run_cycle();
    n_cmp++;
    if (tr_wenb[0] !== 1'b0 || tr_gvld[0] !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL reset_first_idle: got wenb=%b gvld=%b, expected 0 0", tr_wenb[0], tr_gvld[0]);
    end
    run_cycle();
    n_cmp++;
    if (tr_gvld[1] !== 1'b1 || tr_gid[1] !== 2'd0) begin
      n_mis++;
      $display("[TB] FAIL reset_first_grant: got gvld=%b gid=%0d, expected 1 0", tr_gvld[1], tr_gid[1]);
    end
  endtask

  task automatic test_single_burst();
    logic [10:0] pat;
    exp_t e;
    int nw;
    clear_stim();
    for (int k = 0; k < 6; k++) begin
      load_word(0, 8'(8'h11 + k));
      expect_word(0, 8'(8'h11 + k));
    end
    apply_reset();
    for (int c = 0; c < 11; c++) run_cycle();
    pat = 11'b00011011110;
    for (int c = 0; c < 11; c++) begin
      n_cmp++;
      if (tr_wenb[c] !== pat[c]) begin
        n_mis++;
        $display("[TB] FAIL single_wenb_c%0d: got %b expected %b", c, tr_wenb[c], pat[c]);
      end
    end
    n_cmp++;
    if (tr_gvld[1] !== 1'b1 || tr_gid[1] !== 2'd0) begin
      n_mis++;
      $display("[TB] FAIL single_grant: got gvld=%b gid=%0d expected 1 0", tr_gvld[1], tr_gid[1]);
    end
    nw = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (tr_wenb[c]) begin
        nw++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL single_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data || tr_gid[c] !== e.id || tr_ready[c] !== 4'(1 << e.id)) begin
            n_mis++;
            $display("[TB] FAIL single_word: cycle %0d got id=%0d din=%h ready=%b expected id=%0d din=%h",
                     c, tr_gid[c], tr_din[c], tr_ready[c], e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (nw !== 6) begin
      n_mis++;
      $display("[TB] FAIL single_count: got %0d writes expected 6", nw);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int nw;
    int nidle;
    clear_stim();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) load_word(i, 8'(i*16 + k));
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++) expect_word(b, 8'(b*16 + k));
    for (int k = 4; k < 8; k++) expect_word(0, 8'(k));
    apply_reset();
    for (int c = 0; c < 25; c++) run_cycle();
    nw = 0;
    nidle = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c >= 1 && !tr_wenb[c]) nidle++;
      if (tr_wenb[c]) begin
        nw++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL rr_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data || tr_gid[c] !== e.id) begin
            n_mis++;
            $display("[TB] FAIL rr_word: cycle %0d got id=%0d din=%h expected id=%0d din=%h",
                     c, tr_gid[c], tr_din[c], e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (nw !== 20) begin
      n_mis++;
      $display("[TB] FAIL rr_count: got %0d writes expected 20", nw);
    end
    n_cmp++;
    if (nidle !== 4) begin
      n_mis++;
      $display("[TB] FAIL rr_gaps: got %0d idle cycles expected 4", nidle);
    end
    for (int b = 1; b <= 4; b++) begin
      n_cmp++;
      if (tr_wenb[5*b] !== 1'b0) begin
        n_mis++;
        $display("[TB] FAIL rr_gap_pos: cycle %0d got wenb=%b expected 0", 5*b, tr_wenb[5*b]);
      end
    end
  endtask

  task automatic test_full_stall();
    exp_t e;
    int nw;
    int novf;
    clear_stim();
    for (int k = 0; k < 4; k++) begin
      load_word(1, 8'(8'hB0 + k));
      expect_word(1, 8'(8'hB0 + k));
    end
    for (int c = 3; c <= 7; c++) full_at[c] = 1'b1;
    apply_reset();
    for (int c = 0; c < 12; c++) run_cycle();
    for (int c = 3; c <= 7; c++) begin
      n_cmp++;
      if (tr_wenb[c] !== 1'b0 || tr_ready[c] !== 4'b0 || tr_gvld[c] !== 1'b1 || tr_gid[c] !== 2'd1) begin
        n_mis++;
        $display("[TB] FAIL full_hold_c%0d: got wenb=%b ready=%b gvld=%b gid=%0d expected 0 0000 1 1",
                 c, tr_wenb[c], tr_ready[c], tr_gvld[c], tr_gid[c]);
      end
    end
    n_cmp++;
    if (tr_wenb[8] !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL full_resume: got wenb=%b expected 1", tr_wenb[8]);
    end
    nw = 0;
    novf = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (tr_wenb[c] && tr_full[c]) novf++;
      if (tr_wenb[c]) begin
        nw++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL full_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data || tr_gid[c] !== e.id) begin
            n_mis++;
            $display("[TB] FAIL full_word: cycle %0d got id=%0d din=%h expected id=%0d din=%h",
                     c, tr_gid[c], tr_din[c], e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (nw !== 4 || novf !== 0) begin
      n_mis++;
      $display("[TB] FAIL full_count: got %0d writes %0d overflow expected 4 0", nw, novf);
    end
  endtask

  task automatic test_release();
    exp_t e;
    clear_stim();
    load_word(2, 8'hC0);
    load_word(3, 8'hD0);
    load_word(3, 8'hD1);
    load_word(0, 8'hE0);
    start_at[0] = 2;
    expect_word(2, 8'hC0);
    expect_word(3, 8'hD0);
    expect_word(3, 8'hD1);
    expect_word(0, 8'hE0);
    apply_reset();
    for (int c = 0; c < 10; c++) run_cycle();
    n_cmp++;
    if (tr_wenb[2] !== 1'b0 || tr_gvld[3] !== 1'b0) begin
      n_mis++;
      $display("[TB] FAIL release_drop: got wenb=%b gvld_next=%b expected 0 0", tr_wenb[2], tr_gvld[3]);
    end
    n_cmp++;
    if (tr_gvld[4] !== 1'b1 || tr_gid[4] !== 2'd3) begin
      n_mis++;
      $display("[TB] FAIL release_next: got gvld=%b gid=%0d expected 1 3", tr_gvld[4], tr_gid[4]);
    end
    for (int c = 0; c < ncyc; c++) begin
      if (tr_wenb[c]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL release_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data || tr_gid[c] !== e.id) begin
            n_mis++;
            $display("[TB] FAIL release_word: cycle %0d got id=%0d din=%h expected id=%0d din=%h",
                     c, tr_gid[c], tr_din[c], e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_mis++;
      $display("[TB] FAIL release_missing: got %0d words unwritten expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    clear_stim();
    for (int k = 0; k < 4; k++) load_word(0, 8'(8'h20 + k));
    for (int k = 0; k < 4; k++) load_word(1, 8'(8'h30 + k));
    expect_word(0, 8'h20);
    expect_word(0, 8'h21);
    apply_reset();
    for (int c = 0; c < 3; c++) run_cycle();
    n_cmp++;
    if (wenb !== 1'b1) begin
      n_mis++;
      $display("[TB] FAIL midrst_pending: got wenb=%b expected 1", wenb);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wenb, req_ready, grant_vld, din} !== 14'h0) begin
      n_mis++;
      $display("[TB] FAIL midrst_async: got wenb=%b ready=%b gvld=%b din=%h expected all zero",
               wenb, req_ready, grant_vld, din);
    end
    for (int c = 0; c < ncyc; c++) begin
      if (tr_wenb[c]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL midrst_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data) begin
            n_mis++;
            $display("[TB] FAIL midrst_pre_word: cycle %0d got din=%h expected %h", c, tr_din[c], e.data);
          end
        end
      end
    end
    expect_word(0, 8'h22);
    expect_word(0, 8'h23);
    for (int k = 0; k < 4; k++) expect_word(1, 8'(8'h30 + k));
    @(posedge clk);
    #1;
    reset = 1'b0;
    ncyc = 0;
    drive_inputs();
    for (int c = 0; c < 10; c++) run_cycle();
    n_cmp++;
    if (tr_gvld[1] !== 1'b1 || tr_gid[1] !== 2'd0) begin
      n_mis++;
      $display("[TB] FAIL midrst_restart: got gvld=%b gid=%0d expected 1 0", tr_gvld[1], tr_gid[1]);
    end
    for (int c = 0; c < ncyc; c++) begin
      if (tr_wenb[c]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL midrst_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data || tr_gid[c] !== e.id) begin
            n_mis++;
            $display("[TB] FAIL midrst_word: cycle %0d got id=%0d din=%h expected id=%0d din=%h",
                     c, tr_gid[c], tr_din[c], e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_mis++;
      $display("[TB] FAIL midrst_missing: got %0d words unwritten expected 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    clear_stim();
    load_word(0, 8'hA0);
    expect_word(0, 8'hA0);
    expect_word(3, 8'hF0);
    expect_word(3, 8'hF1);
    expect_word(0, 8'hA1);
    expect_word(0, 8'hA2);
    apply_reset();
    for (int c = 0; c < 4; c++) run_cycle();
    load_word(3, 8'hF0);
    load_word(3, 8'hF1);
    load_word(0, 8'hA1);
    load_word(0, 8'hA2);
    drive_inputs();
    for (int c = 0; c < 8; c++) run_cycle();
    n_cmp++;
    if (tr_wenb[4] !== 1'b0 || tr_gvld[5] !== 1'b1 || tr_gid[5] !== 2'd3) begin
      n_mis++;
      $display("[TB] FAIL wrap_first: got wenb4=%b gvld=%b gid=%0d expected 0 1 3", tr_wenb[4], tr_gvld[5], tr_gid[5]);
    end
    n_cmp++;
    if (tr_gvld[9] !== 1'b1 || tr_gid[9] !== 2'd0) begin
      n_mis++;
      $display("[TB] FAIL wrap_second: got gvld=%b gid=%0d expected 1 0", tr_gvld[9], tr_gid[9]);
    end
    for (int c = 0; c < ncyc; c++) begin
      if (tr_wenb[c]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("[TB] FAIL wrap_extra_write: cycle %0d din=%h, expected no write", c, tr_din[c]);
        end else begin
          e = sb.pop_front();
          if (tr_din[c] !== e.data || tr_gid[c] !== e.id) begin
            n_mis++;
            $display("[TB] FAIL wrap_word: cycle %0d got id=%0d din=%h expected id=%0d din=%h",
                     c, tr_gid[c], tr_din[c], e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_mis++;
      $display("[TB] FAIL wrap_missing: got %0d words unwritten expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_release();
    test_reset_mid_burst();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
